// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 channel selector for the pipelined datapath.
// Direct mode picks a channel by index; round-robin mode arbitrates a
// request vector starting after the last granted channel. All outputs
// are flops, so no input reaches an output combinationally.
//
// Transfer semantics: a cycle transfers data only when valid_i is high
// and neither stall_i nor flush_i is asserted (accept). There is no
// ready output. stall_i freezes every register. flush_i clears the
// output stage and overrides stall_i. The result of an accept appears
// on data_o/valid_o/grant_o exactly one cycle later.
module mux_nto1_pipe #(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CHANNELS*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]         select_i,
  input  logic                     mode_i,
  input  logic [CHANNELS-1:0]      req_i,
  input  logic                     valid_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [SIZE-1:0]          data_o,
  output logic                     valid_o,
  output logic [CHANNELS-1:0]      grant_o,
  output logic                     sel_err_o
);

  // Unpacked view of the channel inputs.
  logic [SIZE-1:0] chan [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign chan[g] = data_i[g*SIZE +: SIZE];
  end

  logic [SIZE-1:0]     data_q,    data_d;
  logic                valid_q,   valid_d;
  logic [CHANNELS-1:0] grant_q,   grant_d;
  logic [SEL_W-1:0]    ptr_q,     ptr_d;
  logic                sel_err_q, sel_err_d;

  // Round-robin search: the requester closest after ptr_q wins.
  int  rr_best_dist;
  int  rr_best_idx;
  int  rr_dist;
  logic rr_found;

  // Round-robin winner search over the request vector.
  always_comb begin
    rr_best_dist = CHANNELS;
    rr_best_idx  = 0;
    rr_dist      = 0;
    rr_found     = 1'b0;
    for (int j = 0; j < CHANNELS; j++) begin
      // Distance 0 is the channel right after ptr_q; ptr_q is always
      // below CHANNELS, so the sum never goes negative.
      rr_dist = (j + CHANNELS - int'(ptr_q) - 1) % CHANNELS;
      if (req_i[j] && (rr_dist < rr_best_dist)) begin
        rr_best_dist = rr_dist;
        rr_best_idx  = j;
        rr_found     = 1'b1;
      end
    end
  end

  // Next-state selection: flush beats stall beats accept.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    sel_err_d = sel_err_q;
    if (flush_i) begin
      data_d  = '0;
      valid_d = 1'b0;
      grant_d = '0;
    end else if (stall_i) begin
      // everything holds
    end else if (!valid_i) begin
      // idle cycle: data_o keeps its last value
      valid_d = 1'b0;
      grant_d = '0;
    end else if (!mode_i) begin
      // Direct mode; an out-of-range index yields a valid zero word.
      data_d  = '0;
      grant_d = '0;
      valid_d = 1'b1;
      if (int'(select_i) >= CHANNELS) begin
        sel_err_d = 1'b1;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (int'(select_i) == k) begin
          data_d     = chan[k];
          grant_d[k] = 1'b1;
        end
      end
    end else begin
      // Round-robin mode; no requester means no output this cycle.
      valid_d = 1'b0;
      grant_d = '0;
      if (rr_found) begin
        valid_d = 1'b1;
        ptr_d   = SEL_W'(rr_best_idx);
        for (int k = 0; k < CHANNELS; k++) begin
          if (rr_best_idx == k) begin
            data_d     = chan[k];
            grant_d[k] = 1'b1;
          end
        end
      end
    end
  end

  // State registers; the pointer resets to the last channel so the
  // first round-robin grant goes to channel 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      grant_q   <= '0;
      ptr_q     <= SEL_W'(CHANNELS - 1);
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign grant_o   = grant_q;
  assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe with SIZE=8, CHANNELS=3, SEL_W=2.
module tb_mux_nto1_pipe;

  localparam int SIZE     = 8;
  localparam int CHANNELS = 3;
  localparam int SEL_W    = 2;

  logic                     clk_i;
  logic                     rst_i;
  logic [CHANNELS*SIZE-1:0] data_i;
  logic [SEL_W-1:0]         select_i;
  logic                     mode_i;
  logic [CHANNELS-1:0]      req_i;
  logic                     valid_i;
  logic                     stall_i;
  logic                     flush_i;
  logic [SIZE-1:0]          data_o;
  logic                     valid_o;
  logic [CHANNELS-1:0]      grant_o;
  logic                     sel_err_o;

  int vectors;
  int miscompares;

  mux_nto1_pipe #(
    .SIZE    (SIZE),
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .mode_i   (mode_i),
    .req_i    (req_i),
    .valid_i  (valid_i),
    .stall_i  (stall_i),
    .flush_i  (flush_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .grant_o  (grant_o),
    .sel_err_o(sel_err_o)
  );

  // clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // one comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // full output comparison
  task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                           input logic [2:0] g, input logic e);
    check({tag, ".data"},    32'(data_o),    32'(d));
    check({tag, ".valid"},   32'(valid_o),   32'(v));
    check({tag, ".grant"},   32'(grant_o),   32'(g));
    check({tag, ".sel_err"}, 32'(sel_err_o), 32'(e));
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_i    = 1'b0;
    data_i   = {8'h33, 8'h22, 8'h11};
    select_i = '0;
    mode_i   = 1'b0;
    req_i    = '0;
    valid_i  = 1'b0;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    step();
    step();
    check_out("reset", 8'h00, 1'b0, 3'b000, 1'b0);
    rst_i = 1'b1;

    // direct mode
    valid_i = 1'b1;
    select_i = 2'd0; step(); check_out("dir0", 8'h11, 1'b1, 3'b001, 1'b0);
    select_i = 2'd1; step(); check_out("dir1", 8'h22, 1'b1, 3'b010, 1'b0);
    select_i = 2'd2; step(); check_out("dir2", 8'h33, 1'b1, 3'b100, 1'b0);
    select_i = 2'd3; step(); check_out("dir3_illegal", 8'h00, 1'b1, 3'b000, 1'b1);
    select_i = 2'd0; step(); check_out("dir0_sticky", 8'h11, 1'b1, 3'b001, 1'b1);

    // idle cycle keeps data
    valid_i = 1'b0; step(); check_out("idle", 8'h11, 1'b0, 3'b000, 1'b1);

    // reset mid-operation, between edges
    valid_i = 1'b1; select_i = 2'd1; step();
    check_out("pre_reset", 8'h22, 1'b1, 3'b010, 1'b1);
    #3 rst_i = 1'b0;
    #1 check_out("async_reset", 8'h00, 1'b0, 3'b000, 1'b0);

    // round-robin from reset
    #1;
    mode_i = 1'b1; req_i = 3'b111; rst_i = 1'b1;
    step(); check_out("rr_a", 8'h11, 1'b1, 3'b001, 1'b0);
    step(); check_out("rr_b", 8'h22, 1'b1, 3'b010, 1'b0);
    step(); check_out("rr_c", 8'h33, 1'b1, 3'b100, 1'b0);
    step(); check_out("rr_d", 8'h11, 1'b1, 3'b001, 1'b0);
    req_i = 3'b101;
    step(); check_out("rr_101a", 8'h33, 1'b1, 3'b100, 1'b0);
    step(); check_out("rr_101wrap", 8'h11, 1'b1, 3'b001, 1'b0);
    req_i = 3'b000;
    step(); check_out("rr_noreq", 8'h11, 1'b0, 3'b000, 1'b0);

    // stall freezes outputs and pointer
    req_i = 3'b111;
    step(); check_out("rr_pre_stall", 8'h22, 1'b1, 3'b010, 1'b0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_out("stall_hold", 8'h22, 1'b1, 3'b010, 1'b0);
    end
    stall_i = 1'b0;
    step(); check_out("post_stall", 8'h33, 1'b1, 3'b100, 1'b0);

    // flush beats stall
    flush_i = 1'b1; stall_i = 1'b1;
    step(); check_out("flush_stall", 8'h00, 1'b0, 3'b000, 1'b0);
    flush_i = 1'b0; stall_i = 1'b0;
    step(); check_out("post_flush", 8'h11, 1'b1, 3'b001, 1'b0);

    // mode switching keeps the pointer
    step(); check_out("rr_ch1", 8'h22, 1'b1, 3'b010, 1'b0);
    mode_i = 1'b0; select_i = 2'd2;
    step(); check_out("sw_direct", 8'h33, 1'b1, 3'b100, 1'b0);
    mode_i = 1'b1; req_i = 3'b111;
    step(); check_out("sw_rr", 8'h33, 1'b1, 3'b100, 1'b0);

    // round-robin ignores an illegal select
    data_i = {8'hC3, 8'h5A, 8'hA5};
    select_i = 2'd3; req_i = 3'b010;
    step(); check_out("rr_sel_ignored", 8'h5A, 1'b1, 3'b010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised, registered N-to-1 selector for the pipelined datapath; generalises the 3-input datapath mux.
- Used for forwarding and writeback source selection, and for arbitrating shared resources between pipeline stages.
- Two modes:
  - direct: index select;
  - round-robin: request vector arbitration.
- One-cycle registered output, with stall hold, flush, one-hot grant report and sticky illegal-select flag.

Parameters:
- SIZE, 32, data width per channel
- CHANNELS, 3, number of input channels (2..2**SEL_W)
- SEL_W, 2, width of select_i; must satisfy 2**SEL_W >= CHANNELS

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- data_i  input  CHANNELS*SIZE  packed inputs; channel k at data_i[k*SIZE +: SIZE]
- select_i  input  SEL_W  channel index (direct mode)
- mode_i  input  1  0 = direct, 1 = round-robin
- req_i  input  CHANNELS  per-channel request (round-robin mode)
- valid_i  input  1  input cycle qualifier
- stall_i  input  1  hold all registered state
- flush_i  input  1  kill output stage
- data_o  output  SIZE  registered selected data
- valid_o  output  1  data_o valid
- grant_o  output  CHANNELS  registered one-hot of selected channel
- sel_err_o  output  1  sticky: illegal select_i accepted in direct mode

Behaviour:
- Reset (rst_i=0, async, immediate):
  - data_o=0, valid_o=0, grant_o=0, sel_err_o=0.
  - Internal RR pointer ptr=CHANNELS-1, so the first RR grant goes to channel 0.
- Priority per rising edge: flush_i > stall_i > accept.
- Flush (flush_i=1, regardless of stall_i):
  - Next cycle data_o=0, valid_o=0, grant_o=0.
  - ptr and sel_err_o unchanged.
- Stall (stall_i=1, flush_i=0): data_o, valid_o, grant_o, ptr, sel_err_o all hold.
- accept = valid_i & !stall_i & !flush_i.
- No-accept cycle with valid_i=0, stall_i=0, flush_i=0:
  - Next cycle valid_o=0 and grant_o=0.
  - data_o holds its last value.
- Latency is exactly 1 cycle from the accepting edge to data_o/valid_o.
- Direct mode (mode_i=0), on accept:
  - select_i < CHANNELS: data_o = channel[select_i], grant_o = 1<<select_i, valid_o=1.
  - select_i >= CHANNELS: data_o=0, grant_o=0, valid_o=1, sel_err_o set to 1. sel_err_o stays 1 until reset.
  - req_i and ptr are ignored; ptr is not modified.
- Round-robin mode (mode_i=1), on accept:
  - Search order is ptr+1, ptr+2, ... modulo CHANNELS, wrapping from CHANNELS-1 to 0.
  - Grant the first channel with req_i set: data_o = its data, grant_o one-hot, valid_o=1, ptr = granted index.
  - req_i == 0: valid_o=0, grant_o=0, data_o holds, ptr unchanged.
  - A single persistent requester is granted every accept cycle.
  - select_i is ignored and never sets sel_err_o.
- Mode change: takes effect on the next accepting edge. The ptr value is retained across mode switches.
- Combinational paths: none from inputs to outputs; all outputs are registers.
- Width rules:
  - Data is passed bit-exact with no extension.
  - grant_o has exactly zero or one bit set at all times.

Test Plan:
- Reset mid-operation: SIZE=8, CHANNELS=3, direct mode, valid_o=1. Assert rst_i=0 between edges -> data_o=0x00, valid_o=0, grant_o=3'b000, sel_err_o=0 immediately, without waiting for a clock edge.
- Direct mode, data ch0=0x11, ch1=0x22, ch2=0x33, valid_i=1:
  - Drive select_i 0,1,2 on consecutive cycles -> data_o 0x11, 0x22, 0x33, each one cycle late; grant_o 001, 010, 100.
  - Then drive select_i=3 -> data_o=0x00, grant_o=000, valid_o=1, sel_err_o=1.
  - sel_err_o stays 1 after select_i returns to 0.
- Round-robin from reset, req_i=3'b111, valid_i=1 for 4 cycles -> grant_o 001, 010, 100, 001.
  - Then req_i=3'b101 -> grant 100, then 001 (wrap-around).
  - Then req_i=000 -> valid_o=0, grant_o=000.
- Stall: in RR mode with req_i=111, hold stall_i=1 for 3 cycles -> outputs and ptr frozen. After release the next grant follows the frozen ptr without skipping a channel.
- Flush beats stall: valid_o=1 with flush_i=1 and stall_i=1 on the same edge -> data_o=0, valid_o=0, grant_o=0.
  - Next accepting RR grant continues from the pre-flush ptr.
- Mode switch: RR grants channel 1, switch to direct select_i=2 -> grant_o=100. Switch back to RR with req_i=111 -> grant_o=100 (ptr was still 1, so search starts at channel 2).
